// File: rtl/fifo_sync_mc.sv
// rtl/fifo_sync_mc.sv - multi-channel synchronous FIFO with a shared memory
// One write and one read port, per-channel pointers, counts, registered flags and flush.
module fifo_sync_mc #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 4,
  parameter int NUM_CH    = 4,
  parameter int CH_WIDTH  = 2,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_en_i,
  input  logic [CH_WIDTH-1:0]             wr_ch_i,
  input  logic [WIDTH-1:0]                wdata_i,
  input  logic                            rd_en_i,
  input  logic [CH_WIDTH-1:0]             rd_ch_i,
  input  logic [NUM_CH-1:0]               flush_i,
  output logic [WIDTH-1:0]                rdata_o,
  output logic                            rvalid_o,
  output logic [NUM_CH-1:0]               full_o,
  output logic [NUM_CH-1:0]               empty_o,
  output logic [NUM_CH-1:0]               almost_full_o,
  output logic [NUM_CH-1:0]               almost_empty_o,
  output logic [NUM_CH*(PTR_WIDTH+1)-1:0] count_o,
  output logic                            wr_error_o,
  output logic                            rd_error_o
);

  localparam int CW = PTR_WIDTH + 1;
  localparam int AW = CH_WIDTH + PTR_WIDTH;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] LP_AE    = CW'(AE_LEVEL);

  logic [WIDTH-1:0]  r_mem [NUM_CH*DEPTH];
  logic [CW-1:0]     r_wr_ptr [NUM_CH];
  logic [CW-1:0]     r_rd_ptr [NUM_CH];
  logic [CW-1:0]     r_count  [NUM_CH];
  logic [NUM_CH-1:0] r_full;
  logic [NUM_CH-1:0] r_empty;
  logic [NUM_CH-1:0] r_afull;
  logic [NUM_CH-1:0] r_aempty;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_rvalid;
  logic              r_wr_error;
  logic              r_rd_error;

  logic [NUM_CH-1:0] w_wr_acc;
  logic [NUM_CH-1:0] w_rd_acc;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;
  logic [CW-1:0]     w_wr_ptr_nxt [NUM_CH];
  logic [CW-1:0]     w_rd_ptr_nxt [NUM_CH];
  logic [CW-1:0]     w_count_nxt  [NUM_CH];

  // Per-channel decode keeps out-of-range channel selects from ever indexing state.
  always_comb begin
    w_wr_acc  = '0;
    w_rd_acc  = '0;
    w_wr_addr = '0;
    w_rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_wr_acc[c] = wr_en_i && (wr_ch_i == CH_WIDTH'(c)) && !r_full[c] && !flush_i[c];
      w_rd_acc[c] = rd_en_i && (rd_ch_i == CH_WIDTH'(c)) && !r_empty[c] && !flush_i[c];
      if (w_wr_acc[c]) w_wr_addr = {CH_WIDTH'(c), r_wr_ptr[c][PTR_WIDTH-1:0]};
      if (w_rd_acc[c]) w_rd_addr = {CH_WIDTH'(c), r_rd_ptr[c][PTR_WIDTH-1:0]};
      if (flush_i[c]) begin
        w_wr_ptr_nxt[c] = '0;
        w_rd_ptr_nxt[c] = '0;
        w_count_nxt[c]  = '0;
      end else begin
        w_wr_ptr_nxt[c] = r_wr_ptr[c] + CW'(w_wr_acc[c]);
        w_rd_ptr_nxt[c] = r_rd_ptr[c] + CW'(w_rd_acc[c]);
        w_count_nxt[c]  = r_count[c] + CW'(w_wr_acc[c]) - CW'(w_rd_acc[c]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (|w_wr_acc) r_mem[w_wr_addr] <= wdata_i;
  end

  // Flags come from the next count so they line up with count_o every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_count[c]  <= '0;
      end
      r_full     <= '0;
      r_empty    <= '1;
      r_afull    <= '0;
      r_aempty   <= '1;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_wr_error <= 1'b0;
      r_rd_error <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wr_ptr[c] <= w_wr_ptr_nxt[c];
        r_rd_ptr[c] <= w_rd_ptr_nxt[c];
        r_count[c]  <= w_count_nxt[c];
        r_full[c]   <= (w_count_nxt[c] == LP_DEPTH);
        r_empty[c]  <= (w_count_nxt[c] == '0);
        r_afull[c]  <= (w_count_nxt[c] >= LP_AF);
        r_aempty[c] <= (w_count_nxt[c] <= LP_AE);
      end
      if (|w_rd_acc) r_rdata <= r_mem[w_rd_addr];
      r_rvalid   <= |w_rd_acc;
      r_wr_error <= wr_en_i && !(|w_wr_acc);
      r_rd_error <= rd_en_i && !(|w_rd_acc);
    end
  end

  always_comb begin
    count_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      count_o[c*CW +: CW] = r_count[c];
    end
  end

  assign rdata_o        = r_rdata;
  assign rvalid_o       = r_rvalid;
  assign full_o         = r_full;
  assign empty_o        = r_empty;
  assign almost_full_o  = r_afull;
  assign almost_empty_o = r_aempty;
  assign wr_error_o     = r_wr_error;
  assign rd_error_o     = r_rd_error;

endmodule

// File: tb/tb_fifo_sync_mc.sv
// tb/tb_fifo_sync_mc.sv - directed self-checking bench for fifo_sync_mc
module tb_fifo_sync_mc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_en_i;
  logic [1:0]  wr_ch_i;
  logic [7:0]  wdata_i;
  logic        rd_en_i;
  logic [1:0]  rd_ch_i;
  logic [3:0]  flush_i;
  logic [7:0]  rdata_o;
  logic        rvalid_o;
  logic [3:0]  full_o;
  logic [3:0]  empty_o;
  logic [3:0]  almost_full_o;
  logic [3:0]  almost_empty_o;
  logic [19:0] count_o;
  logic        wr_error_o;
  logic        rd_error_o;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_sync_mc dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_ch_i(wr_ch_i), .wdata_i(wdata_i),
    .rd_en_i(rd_en_i), .rd_ch_i(rd_ch_i), .flush_i(flush_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .count_o(count_o), .wr_error_o(wr_error_o), .rd_error_o(rd_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] cnt(input int c);
    return count_o[c*5 +: 5];
  endfunction

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; wr_ch_i = '0; wdata_i = '0;
    rd_en_i = 1'b0; rd_ch_i = '0; flush_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_empty", 32'(empty_o), 32'hF);
    chk("rst_aempty", 32'(almost_empty_o), 32'hF);
    chk("rst_full", 32'(full_o), 32'h0);
    chk("rst_afull", 32'(almost_full_o), 32'h0);
    chk("rst_count", 32'(count_o), 32'h0);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_rdata", 32'(rdata_o), 32'h0);
    chk("rst_errs", 32'({wr_error_o, rd_error_o}), 32'h0);

    // Fill channel 1
    for (int i = 0; i < 16; i++) begin
      wr_en_i = 1'b1; wr_ch_i = 2'd1; wdata_i = 8'(i);
      tick();
      chk("fill_count", 32'(cnt(1)), 32'(i + 1));
      chk("fill_afull1", 32'(almost_full_o[1]), 32'((i + 1) >= 12));
    end
    wr_en_i = 1'b0;
    chk("full_vec", 32'(full_o), 32'h2);
    chk("aempty_vec", 32'(almost_empty_o), 32'hD);

    // Overflow write
    wr_en_i = 1'b1; wr_ch_i = 2'd1; wdata_i = 8'hFF;
    tick();
    wr_en_i = 1'b0;
    chk("ovf_wr_error", 32'(wr_error_o), 32'h1);
    chk("ovf_count", 32'(cnt(1)), 32'd16);
    tick();
    chk("ovf_pulse_end", 32'(wr_error_o), 32'h0);

    // Drain channel 1 in order
    for (int i = 0; i < 16; i++) begin
      rd_en_i = 1'b1; rd_ch_i = 2'd1;
      tick();
      chk("drain_rvalid", 32'(rvalid_o), 32'h1);
      chk("drain_rdata", 32'(rdata_o), 32'(i));
    end
    rd_en_i = 1'b0;
    chk("drain_empty", 32'(empty_o), 32'hF);
    tick();
    chk("idle_rvalid", 32'(rvalid_o), 32'h0);

    // Underflow read
    rd_en_i = 1'b1; rd_ch_i = 2'd1;
    tick();
    rd_en_i = 1'b0;
    chk("udf_rd_error", 32'(rd_error_o), 32'h1);
    chk("udf_rvalid", 32'(rvalid_o), 32'h0);
    chk("udf_rdata_hold", 32'(rdata_o), 32'h0F);
    tick();
    chk("udf_pulse_end", 32'(rd_error_o), 32'h0);

    // Interleave channels 0 and 2
    wr_en_i = 1'b1; wr_ch_i = 2'd0; wdata_i = 8'hA0;
    tick();
    wr_ch_i = 2'd2; wdata_i = 8'hB0;
    tick();
    wr_en_i = 1'b0;
    chk("il_count0", 32'(cnt(0)), 32'd1);
    chk("il_count2", 32'(cnt(2)), 32'd1);
    rd_en_i = 1'b1; rd_ch_i = 2'd2;
    tick();
    chk("il_rd2", 32'(rdata_o), 32'hB0);
    rd_ch_i = 2'd0;
    tick();
    rd_en_i = 1'b0;
    chk("il_rd0", 32'(rdata_o), 32'hA0);
    chk("il_empty", 32'(empty_o), 32'hF);

    // Channel 3: five entries then simultaneous read and write
    for (int i = 0; i < 5; i++) begin
      wr_en_i = 1'b1; wr_ch_i = 2'd3; wdata_i = 8'(8'h30 + i);
      tick();
    end
    chk("c3_count5", 32'(cnt(3)), 32'd5);
    wdata_i = 8'h35; rd_en_i = 1'b1; rd_ch_i = 2'd3;
    tick();
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    chk("rw_count", 32'(cnt(3)), 32'd5);
    chk("rw_rdata", 32'(rdata_o), 32'h30);
    chk("rw_errs", 32'({wr_error_o, rd_error_o}), 32'h0);

    // Flush channel 3 against a same-cycle write
    flush_i = 4'b1000; wr_en_i = 1'b1; wr_ch_i = 2'd3; wdata_i = 8'h99;
    tick();
    flush_i = '0; wr_en_i = 1'b0;
    chk("fl_count3", 32'(cnt(3)), 32'd0);
    chk("fl_wr_error", 32'(wr_error_o), 32'h1);
    chk("fl_empty", 32'(empty_o), 32'hF);

    // Reset with data queued and a read in flight
    for (int i = 0; i < 8; i++) begin
      wr_en_i = 1'b1; wr_ch_i = 2'd0; wdata_i = 8'(8'h50 + i);
      tick();
    end
    wr_en_i = 1'b0;
    rd_en_i = 1'b1; rd_ch_i = 2'd0;
    tick();
    chk("pre_rst_rvalid", 32'(rvalid_o), 32'h1);
    chk("pre_rst_rdata", 32'(rdata_o), 32'h50);
    chk("pre_rst_count", 32'(cnt(0)), 32'd7);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; rd_en_i = 1'b0;
    chk("mid_rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("mid_rst_count", 32'(count_o), 32'h0);
    chk("mid_rst_empty", 32'(empty_o), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_mc.md
Name: fifo_sync_mc

Overview:
- Parametrised multi-channel synchronous FIFO; next generation of the team's single-channel async FIFO, for designs where producer and consumer share one clock.
- Holds NUM_CH independent queues, each DEPTH deep, behind one write port and one read port, with channel select on each port.
- Adds per-channel occupancy counts, programmable almost-full/almost-empty flags and per-channel flush.
- Sits between a channelised producer (e.g. packet demux) and an arbitrated consumer.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 16: entries per channel; must equal 2**PTR_WIDTH.
- PTR_WIDTH, 4: address bits per channel.
- NUM_CH, 4: number of channels, from 1 to 16.
- CH_WIDTH, 2: channel-select width; must satisfy 2**CH_WIDTH >= NUM_CH.
- AF_LEVEL, 12: almost_full_o[c] asserts when count[c] >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty_o[c] asserts when count[c] <= AE_LEVEL.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  write request.
- wr_ch_i  in  CH_WIDTH  write channel select.
- wdata_i  in  WIDTH  write data.
- rd_en_i  in  1  read request.
- rd_ch_i  in  CH_WIDTH  read channel select.
- flush_i  in  NUM_CH  per-channel flush, one bit per channel.
- rdata_o  out  WIDTH  read data; registered.
- rvalid_o  out  1  rdata_o valid this cycle.
- full_o  out  NUM_CH  per-channel full.
- empty_o  out  NUM_CH  per-channel empty.
- almost_full_o  out  NUM_CH  per-channel almost full.
- almost_empty_o  out  NUM_CH  per-channel almost empty.
- count_o  out  NUM_CH*(PTR_WIDTH+1)  per-channel occupancy; channel c occupies bits [c*(PTR_WIDTH+1) +: PTR_WIDTH+1].
- wr_error_o  out  1  one-cycle pulse on a rejected write.
- rd_error_o  out  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset, sampled on clk_i rising edge while rst_i=1:
  - All pointers and counts go to 0.
  - empty_o and almost_empty_o go to all 1.
  - full_o and almost_full_o go to all 0.
  - rdata_o=0, rvalid_o=0, wr_error_o=0, rd_error_o=0.
  - Storage contents are not reset.
  - Reset mid-operation drops all queued data and any read in flight; rvalid_o is 0 on the cycle after reset.
- Storage: one memory of NUM_CH*DEPTH words, addressed {ch, ptr}. Each channel has a wr_ptr, rd_ptr and count, each PTR_WIDTH+1 bits. Pointers wrap modulo DEPTH.
- Write acceptance: accepted iff wr_en_i=1, wr_ch_i < NUM_CH, full_o[wr_ch_i]=0 and flush_i[wr_ch_i]=0.
  - Accepted: data stored at wr_ptr; wr_ptr and count increment.
  - Rejected: wr_error_o pulses high on the next cycle; state is unchanged.
  - When full_o[ch]=1, the write is rejected even if the same channel is read in the same cycle. Flags are always evaluated on pre-edge state.
- Read acceptance: accepted iff rd_en_i=1, rd_ch_i < NUM_CH, empty_o[rd_ch_i]=0 and flush_i[rd_ch_i]=0.
  - Accepted: on the next cycle, rdata_o = mem[{ch, rd_ptr}] and rvalid_o=1; rd_ptr increments and count decrements. Latency is 1 cycle.
  - Rejected: rd_error_o pulses high on the next cycle; rvalid_o=0; rdata_o holds its previous value.
  - A read of an empty channel in the same cycle as a write to it is rejected; there is no write-through.
- Simultaneous accepted read and write:
  - Same channel: count is unchanged; both pointers advance.
  - Different channels: each channel updates independently.
- Flags are registered and consistent with count_o on the same cycle:
  - full_o[c] = (count==DEPTH)
  - empty_o[c] = (count==0)
  - almost_full_o[c] = (count>=AF_LEVEL)
  - almost_empty_o[c] = (count<=AE_LEVEL)
- Flush: flush_i[c]=1 sets channel c's pointers and count to 0 on the next edge.
  - Flush has priority over a same-cycle read or write on c; that read or write is rejected and its error pulses.
  - Other channels are unaffected.
- Both wr_error_o and rd_error_o may pulse in the same cycle.

Test Plan:
- Reset, then 16 writes 0x00..0x0F to channel 1 -> full_o=4'b0010; count_o for channel 1 = 16; almost_full_o[1] rises on the edge where count goes from 11 to 12.
- A 17th write to channel 1 -> wr_error_o pulses once; count stays at 16.
- 16 reads from channel 1 -> rdata_o = 0x00..0x0F in order, each 1 cycle after its rd_en_i, with rvalid_o=1; then empty_o[1]=1.
- An additional read from empty channel 1 -> rd_error_o pulses once; rvalid_o=0.
- Interleave: write 0xA0 to channel 0 and 0xB0 to channel 2, then read channel 2 then channel 0 -> rdata_o = 0xB0 then 0xA0; no cross-channel leakage.
- Channel 3 holding 5 entries: simultaneous read and write on channel 3 -> count stays at 5.
- flush_i=4'b1000 with wr_en_i to channel 3 in the same cycle -> count for channel 3 = 0; wr_error_o pulses.
- Assert rst_i with 8 entries queued and a read in flight -> next cycle: all counts 0, empty_o=4'b1111, rvalid_o=0.
